// File: rtl/spi_ram_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_ram_arbiter_if: SPI rx/tx, host port and RAM port bundle.  rev 1.0   |
// +--------------------------------------------------------------------------+
interface spi_ram_arbiter_if #(
   parameter int DATA_W    = 8,
   parameter int ADDR_SIZE = 8
);
   logic [DATA_W+1:0]    rx_data;
   logic                 rx_valid;
   logic [DATA_W-1:0]    tx_data;
   logic                 tx_valid;
   logic                 spi_overflow;
   logic                 host_req;
   logic                 host_we;
   logic [ADDR_SIZE-1:0] host_addr;
   logic [DATA_W-1:0]    host_wdata;
   logic                 host_gnt;
   logic                 host_rvalid;
   logic [DATA_W-1:0]    host_rdata;
   logic                 ram_en;
   logic                 ram_we;
   logic [ADDR_SIZE-1:0] ram_addr;
   logic [DATA_W-1:0]    ram_wdata;
   logic [DATA_W-1:0]    ram_rdata;

   modport slave (
      input  rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
      output tx_data, tx_valid, spi_overflow, host_gnt, host_rvalid, host_rdata,
             ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
      input  tx_data, tx_valid, spi_overflow, host_gnt, host_rvalid, host_rdata,
             ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface
`default_nettype wire

// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_ram_arbiter: round-robin RAM sharing between SPI ops and host. rev 1.0|
// +--------------------------------------------------------------------------+
module spi_ram_arbiter #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = $clog2(MEM_DEPTH),
   parameter int DATA_W    = 8
) (
   input wire clk,
   input wire rst,
   spi_ram_arbiter_if.slave bus
);
   localparam int ENTRY_W = 1 + ADDR_SIZE + DATA_W;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SPI_ACC  = 2'd1,
      HOST_ACC = 2'd2,
      RD_WAIT  = 2'd3
   } state_t;

   state_t               state;
   logic                 last_grant_spi;
   logic                 rd_for_spi;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic [ENTRY_W-1:0]   fifo_mem [2];
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [1:0]           count;
   logic [DATA_W-1:0]    tx_data_r;
   logic                 tx_valid_r;
   logic [DATA_W-1:0]    host_rdata_r;
   logic                 host_rvalid_r;
   logic                 overflow_r;

   logic [1:0]           cmd;
   logic                 is_op;
   logic                 pop;
   logic                 push;
   logic [ENTRY_W-1:0]   head;
   logic                 head_we;
   logic [ADDR_SIZE-1:0] head_addr;
   logic [DATA_W-1:0]    head_data;
   logic [ENTRY_W-1:0]   new_entry;

   assign cmd       = bus.rx_data[DATA_W+1:DATA_W];
   assign is_op     = bus.rx_valid && cmd[0];
   assign pop       = (state == SPI_ACC);
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
   assign push      = is_op && ((count != 2'd2) || pop);
   assign head      = fifo_mem[rd_ptr];
   assign head_we   = head[ENTRY_W-1];
   assign head_addr = head[ENTRY_W-2 -: ADDR_SIZE];
   assign head_data = head[DATA_W-1:0];
   assign new_entry = cmd[1] ? {1'b0, rd_addr, {DATA_W{1'b0}}}
                             : {1'b1, wr_addr, bus.rx_data[DATA_W-1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         last_grant_spi <= 1'b0;
         rd_for_spi     <= 1'b0;
         wr_addr        <= '0;
         rd_addr        <= '0;
         fifo_mem[0]    <= '0;
         fifo_mem[1]    <= '0;
         wr_ptr         <= 1'b0;
         rd_ptr         <= 1'b0;
         count          <= 2'd0;
         tx_data_r      <= '0;
         tx_valid_r     <= 1'b0;
         host_rdata_r   <= '0;
         host_rvalid_r  <= 1'b0;
         overflow_r     <= 1'b0;
      end else begin
         tx_valid_r    <= 1'b0;
         host_rvalid_r <= 1'b0;
         overflow_r    <= is_op && !push;

         if (bus.rx_valid && (cmd == 2'b00)) wr_addr <= bus.rx_data[ADDR_SIZE-1:0];
         if (bus.rx_valid && (cmd == 2'b10)) rd_addr <= bus.rx_data[ADDR_SIZE-1:0];

         if (push) begin
            fifo_mem[wr_ptr] <= new_entry;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};

         case (state)
            IDLE: begin
               if ((count != 2'd0) && (!bus.host_req || !last_grant_spi)) state <= SPI_ACC;
               else if (bus.host_req)                                      state <= HOST_ACC;
            end
            SPI_ACC: begin
               last_grant_spi <= 1'b1;
               rd_for_spi     <= 1'b1;
               state          <= head_we ? IDLE : RD_WAIT;
            end
            HOST_ACC: begin
               last_grant_spi <= 1'b0;
               rd_for_spi     <= 1'b0;
               state          <= bus.host_we ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
               if (rd_for_spi) begin
                  tx_data_r  <= bus.ram_rdata;
                  tx_valid_r <= 1'b1;
               end else begin
                  host_rdata_r  <= bus.ram_rdata;
                  host_rvalid_r <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      bus.host_gnt  = 1'b0;
      case (state)
         SPI_ACC: begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = head_we;
            bus.ram_addr  = head_addr;
            bus.ram_wdata = head_data;
         end
         HOST_ACC: begin
            bus.ram_en    = 1'b1;
            bus.host_gnt  = 1'b1;
            bus.ram_we    = bus.host_we;
            bus.ram_addr  = bus.host_addr;
            bus.ram_wdata = bus.host_wdata;
         end
         default: ;
      endcase
   end

   assign bus.tx_data      = tx_data_r;
   assign bus.tx_valid     = tx_valid_r;
   assign bus.host_rdata   = host_rdata_r;
   assign bus.host_rvalid  = host_rvalid_r;
   assign bus.spi_overflow = overflow_r;
endmodule
`default_nettype wire

// File: tb/tb_spi_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_ram_arbiter: vector table + scoreboard bench for the arbiter.     |
// +--------------------------------------------------------------------------+
module tb_spi_ram_arbiter;
   logic clk;
   logic rst;

   spi_ram_arbiter_if #(.DATA_W(8), .ADDR_SIZE(8)) bus ();

   spi_ram_arbiter #(.MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic       src;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } ram_t;

   typedef struct {
      bit         host;
      logic [9:0] word;
      bit         e_ram;
      bit         e_we;
      logic [7:0] e_addr;
      logic [7:0] e_wdata;
      logic [7:0] e_rd;
   } vec_t;

   logic [7:0] mem [256];
   ram_t       exp_ram  [$];
   logic [7:0] exp_tx   [$];
   logic [7:0] exp_host [$];

   int  n_checks = 0;
   int  n_pass   = 0;
   int  cyc      = 0;
   int  ram_cnt  = 0;
   int  ram_cyc  = 0;
   int  tx_cyc   = 0;
   int  rv_cyc   = 0;
   int  gnt_cyc  = 0;
   int  ovf_cnt  = 0;
   bit  started  = 0;
   vec_t tbl [20];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
         else            bus.ram_rdata     <= mem[bus.ram_addr];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (started) begin
         if (bus.ram_en) begin
            ram_cnt++;
            ram_cyc = cyc;
            if (exp_ram.size() == 0) chk("ram_unexpected", 32'd1, 32'd0);
            else begin
               ram_t e;
               ram_t a;
               e = exp_ram.pop_front();
               a = '{bus.host_gnt, bus.ram_we, bus.ram_addr, bus.ram_we ? bus.ram_wdata : 8'h00};
               chk("ram_access", 32'(a), 32'(e));
            end
         end else begin
            chk("ram_idle_zero", 32'({bus.host_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'd0);
         end
         if (bus.host_gnt) gnt_cyc = cyc;
         if (bus.spi_overflow) ovf_cnt++;
         if (bus.tx_valid) begin
            tx_cyc = cyc;
            if (exp_tx.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
            else chk("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
         end
         if (bus.host_rvalid) begin
            rv_cyc = cyc;
            if (exp_host.size() == 0) chk("host_rvalid_unexpected", 32'd1, 32'd0);
            else chk("host_rdata", 32'(bus.host_rdata), 32'(exp_host.pop_front()));
         end
      end
   end

   function automatic vec_t v_spi(logic [9:0] w, bit er, bit ewe, logic [7:0] ea, logic [7:0] ewd,
                                  logic [7:0] erd);
      vec_t v;
      v = '{host: 1'b0, word: w, e_ram: er, e_we: ewe, e_addr: ea, e_wdata: ewd, e_rd: erd};
      return v;
   endfunction

   function automatic vec_t v_host(bit we, logic [7:0] a, logic [7:0] d, logic [7:0] erd);
      vec_t v;
      v = '{host: 1'b1, word: {we, 1'b0, d}, e_ram: 1'b1, e_we: we, e_addr: a, e_wdata: d, e_rd: erd};
      return v;
   endfunction

   function automatic void expect_ram(bit src, bit we, logic [7:0] a, logic [7:0] d);
      exp_ram.push_back('{src, we, a, we ? d : 8'h00});
   endfunction

   task automatic send_word(input logic [9:0] w);
      bus.rx_data  = w;
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1 bus.rx_valid = 1'b0;
   endtask

   task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] d);
      int n = 0;
      bus.host_we    = we;
      bus.host_addr  = a;
      bus.host_wdata = d;
      bus.host_req   = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.host_gnt && n < 40);
      if (!bus.host_gnt) chk("host_gnt_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1 bus.host_req = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_ram.size() + exp_tx.size() + exp_host.size()) != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      chk("drain_pending", 32'(exp_ram.size() + exp_tx.size() + exp_host.size()), 32'd0);
      exp_ram.delete();
      exp_tx.delete();
      exp_host.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int c0;
      int o0;
      int rc;
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      bus.ram_rdata  = 8'h00;
      rst            = 1'b1;
      bus.rx_data    = 10'h1FF;
      bus.rx_valid   = 1'b1;
      bus.host_req   = 1'b1;
      bus.host_we    = 1'b1;
      bus.host_addr  = 8'hAA;
      bus.host_wdata = 8'h55;

      tbl[0]  = v_spi(10'h03C, 0, 0, 8'h00, 8'h00, 8'h00);
      tbl[1]  = v_spi(10'h1A5, 1, 1, 8'h3C, 8'hA5, 8'h00);
      tbl[2]  = v_spi(10'h23C, 0, 0, 8'h00, 8'h00, 8'h00);
      tbl[3]  = v_spi(10'h300, 1, 0, 8'h3C, 8'h00, 8'hA5);
      tbl[4]  = v_host(1, 8'h10, 8'h55, 8'h00);
      tbl[5]  = v_host(0, 8'h10, 8'h00, 8'h55);
      tbl[6]  = v_spi(10'h010, 0, 0, 8'h00, 8'h00, 8'h00);
      tbl[7]  = v_spi(10'h1C3, 1, 1, 8'h10, 8'hC3, 8'h00);
      tbl[8]  = v_host(0, 8'h10, 8'h00, 8'hC3);
      tbl[9]  = v_spi(10'h0FF, 0, 0, 8'h00, 8'h00, 8'h00);
      tbl[10] = v_spi(10'h100, 1, 1, 8'hFF, 8'h00, 8'h00);
      tbl[11] = v_spi(10'h2FF, 0, 0, 8'h00, 8'h00, 8'h00);
      tbl[12] = v_spi(10'h300, 1, 0, 8'hFF, 8'h00, 8'h00);
      tbl[13] = v_host(1, 8'h00, 8'hFF, 8'h00);
      tbl[14] = v_spi(10'h200, 0, 0, 8'h00, 8'h00, 8'h00);
      tbl[15] = v_spi(10'h300, 1, 0, 8'h00, 8'h00, 8'hFF);
      tbl[16] = v_host(1, 8'hFF, 8'h5A, 8'h00);
      tbl[17] = v_host(0, 8'hFF, 8'h00, 8'h5A);
      tbl[18] = v_spi(10'h210, 0, 0, 8'h00, 8'h00, 8'h00);
      tbl[19] = v_spi(10'h300, 1, 0, 8'h10, 8'h00, 8'hC3);

      // Reset held two edges with SPI and host both requesting.
      @(posedge clk);
      started = 1'b1;
      @(negedge clk);
      chk("reset_spi_host_outs", 32'({bus.tx_data, bus.tx_valid, bus.spi_overflow, bus.host_gnt,
                                      bus.host_rvalid, bus.host_rdata}), 32'd0);
      chk("reset_ram_outs", 32'({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'd0);
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.rx_valid = 1'b0;
      bus.host_req = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("reset_fifo_empty", 32'(ram_cnt), 32'd0);

      for (int i = 0; i < 20; i++) begin
         vec_t v;
         v = tbl[i];
         if (v.e_ram) expect_ram(v.host, v.e_we, v.e_addr, v.e_wdata);
         if (v.e_ram && !v.e_we) begin
            if (v.host) exp_host.push_back(v.e_rd);
            else        exp_tx.push_back(v.e_rd);
         end
         if (v.host) host_op(v.e_we, v.e_addr, v.e_wdata);
         else        send_word(v.word);
         drain();
      end
      chk("tx_data_hold", 32'(bus.tx_data), 32'h0C3);
      chk("host_rdata_hold", 32'(bus.host_rdata), 32'h05A);

      // Latencies from idle (wr_addr=0xFF, rd_addr=0x10 here).
      c0 = cyc;
      expect_ram(0, 1, 8'hFF, 8'h66);
      send_word(10'h166);
      drain();
      chk("spi_wr_latency", 32'(ram_cyc - c0), 32'd2);
      send_word(10'h23C);
      drain();
      c0 = cyc;
      expect_ram(0, 0, 8'h3C, 8'h00);
      exp_tx.push_back(8'hA5);
      send_word(10'h300);
      drain();
      chk("spi_rd_latency", 32'(tx_cyc - c0), 32'd4);
      c0 = cyc;
      expect_ram(1, 0, 8'hFF, 8'h00);
      exp_host.push_back(8'h66);
      host_op(0, 8'hFF, 8'h00);
      drain();
      chk("host_gnt_latency", 32'(gnt_cyc - c0), 32'd1);
      chk("host_rvalid_latency", 32'(rv_cyc - c0), 32'd3);

      // Three SPI writes while a host read occupies the RAM: the third is dropped.
      send_word(10'h020);
      drain();
      o0 = ovf_cnt;
      expect_ram(1, 0, 8'h3C, 8'h00);
      exp_host.push_back(8'hA5);
      expect_ram(0, 1, 8'h20, 8'h31);
      expect_ram(0, 1, 8'h20, 8'h32);
      fork
         host_op(0, 8'h3C, 8'h00);
         begin
            @(posedge clk);
            #1;
            send_word(10'h131);
            send_word(10'h132);
            send_word(10'h133);
         end
      join
      drain();
      chk("overflow_pulse_cycles", 32'(ovf_cnt - o0), 32'd1);
      send_word(10'h220);
      drain();
      expect_ram(0, 0, 8'h20, 8'h00);
      exp_tx.push_back(8'h32);
      send_word(10'h300);
      drain();

      // Contention right after reset: first tie goes to SPI, then alternation.
      pulse_reset();
      expect_ram(0, 1, 8'h20, 8'h11);
      expect_ram(1, 1, 8'h30, 8'h77);
      expect_ram(0, 1, 8'h20, 8'h22);
      send_word(10'h020);
      fork
         begin
            send_word(10'h111);
            send_word(10'h122);
         end
         begin
            @(posedge clk);
            #1;
            host_op(1, 8'h30, 8'h77);
         end
      join
      drain();
      chk("contention_mem_0x30", 32'(mem[8'h30]), 32'h077);
      chk("contention_mem_0x20", 32'(mem[8'h20]), 32'h022);

      // Reset while the SPI read sits in RD_WAIT: its tx_valid must never appear.
      send_word(10'h23C);
      drain();
      rc = ram_cnt;
      expect_ram(0, 0, 8'h3C, 8'h00);
      send_word(10'h300);
      n = 0;
      while (ram_cnt == rc && n < 20) begin
         @(posedge clk);
         n++;
      end
      chk("midrd_ram_seen", 32'(ram_cnt - rc), 32'd1);
      #1;
      pulse_reset();
      repeat (6) @(posedge clk);
      #1;
      chk("midrd_no_pending", 32'(exp_ram.size() + exp_tx.size()), 32'd0);
      send_word(10'h23C);
      drain();
      expect_ram(0, 0, 8'h3C, 8'h00);
      exp_tx.push_back(8'hA5);
      send_word(10'h300);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
